// File: rtl/gantry_gate_deadtime.sv
`default_nettype none
// =====================================================================
// Module   : gantry_gate_deadtime
// Purpose  : Dead-time insertion and shoot-through protection for the
//            three half-bridge legs of the gantry motor. Each leg runs
//            its own IDLE/DEAD/HI/LO state machine, so both switches of
//            a leg are never driven together. There is always at least
//            dead_time+1 idle cycles between one switch turning off and
//            the other switch turning on.
// Ports    : OPB_CLK    - bus clock. This is the only clock.
//            OPB_RST    - synchronous active-high reset.
//            PHASE_IN   - asynchronous commutation request. The pairs
//                         {5,4},{3,2},{1,0} are the {high,low} switches
//                         of legs A, B and C.
//            GATE_DI    - bus write data.
//            GATE_ADDR  - bus address. Only bits [2:0] are decoded.
//            GATE_WE    - single-cycle write strobe.
//            GATE_RE    - read strobe.
//            GATE_DO    - combinational read data. It is 0 when idle.
//            GATE_OUT   - protected gate drive. Same mapping as PHASE_IN.
//            GATE_FAULT - sticky shoot-through fault.
// Revision : 1.0 - initial release
// =====================================================================
module gantry_gate_deadtime #(
  parameter int DT_W = 8
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [5:0]  PHASE_IN,
  input  logic [31:0] GATE_DI,
  input  logic [31:0] GATE_ADDR,
  input  logic        GATE_WE,
  input  logic        GATE_RE,
  output logic [31:0] GATE_DO,
  output logic [5:0]  GATE_OUT,
  output logic        GATE_FAULT
);

  localparam logic [1:0]      ST_IDLE  = 2'd0;
  localparam logic [1:0]      ST_DEAD  = 2'd1;
  localparam logic [1:0]      ST_HI    = 2'd2;
  localparam logic [1:0]      ST_LO    = 2'd3;
  localparam logic [DT_W-1:0] DT_RESET = DT_W'(16);

  logic [5:0]      sync1_d, sync1_q;
  logic [5:0]      phase_s_d, phase_s_q;
  logic [DT_W-1:0] dead_time_d, dead_time_q;
  logic            enable_d, enable_q;
  logic            fault_d, fault_q;
  logic            wr_dt, wr_ctl, shoot, force_idle;
  logic [5:0]      leg_code;    // {C,B,A} state codes
  logic            unused_bits;

  assign unused_bits = ^{GATE_ADDR[31:3], GATE_DI[31:DT_W]};

  // Control registers and the shoot-through detector
  always_comb begin
    sync1_d   = PHASE_IN;
    phase_s_d = sync1_q;
    wr_dt     = GATE_WE && (GATE_ADDR[2:0] == 3'd1);
    wr_ctl    = GATE_WE && (GATE_ADDR[2:0] == 3'd2);

    dead_time_d = wr_dt  ? GATE_DI[DT_W-1:0] : dead_time_q;
    enable_d    = wr_ctl ? GATE_DI[0]        : enable_q;

    shoot = (phase_s_q[5] & phase_s_q[4]) |
            (phase_s_q[3] & phase_s_q[2]) |
            (phase_s_q[1] & phase_s_q[0]);

    // A new shoot-through request beats a simultaneous clear
    fault_d = shoot | (fault_q & ~(wr_ctl & GATE_DI[1]));

    // Use next-state values so the gates drop on the same edge that
    // raises the fault or applies the disabling write.
    force_idle = fault_d | ~enable_d;
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      sync1_q     <= '0;
      phase_s_q   <= '0;
      dead_time_q <= DT_RESET;
      enable_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      phase_s_q   <= phase_s_d;
      dead_time_q <= dead_time_d;
      enable_q    <= enable_d;
      fault_q     <= fault_d;
    end
  end

  // Per-leg dead-time state machines. g = 0 is leg C, g = 2 is leg A.
  for (genvar g = 0; g < 3; g++) begin : g_leg
    logic [1:0]      req;
    logic [1:0]      state_d, state_q;
    logic [DT_W-1:0] cnt_d, cnt_q;
    logic [1:0]      drive_d, drive_q;

    assign req = phase_s_q[2*g +: 2];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (force_idle) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (req == 2'b10 || req == 2'b01) begin
              state_d = ST_DEAD;
              cnt_d   = dead_time_q;
            end
          end
          ST_HI: begin
            if (req != 2'b10) begin
              state_d = ST_DEAD;
              cnt_d   = dead_time_q;
            end
          end
          ST_LO: begin
            if (req != 2'b01) begin
              state_d = ST_DEAD;
              cnt_d   = dead_time_q;
            end
          end
          ST_DEAD: begin
            // The count loaded at entry always runs to completion.
            // After that, an 11 request holds the leg here until the
            // fault forces it to IDLE.
            if (cnt_q != '0) begin
              cnt_d = cnt_q - DT_W'(1);
            end else if (req == 2'b10) begin
              state_d = ST_HI;
            end else if (req == 2'b01) begin
              state_d = ST_LO;
            end else if (req == 2'b00) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      // The drive is registered from the next state, so the gates
      // change on the same edge as the state.
      drive_d = {state_d == ST_HI, state_d == ST_LO};
    end

    always_ff @(posedge OPB_CLK) begin
      if (OPB_RST) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        drive_q <= 2'b00;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        drive_q <= drive_d;
      end
    end

    assign GATE_OUT[2*g +: 2]     = drive_q;
    assign leg_code[4-2*g +: 2]   = state_q;
  end

  assign GATE_FAULT = fault_q;

  // Read mux
  always_comb begin
    GATE_DO = '0;
    if (GATE_RE) begin
      case (GATE_ADDR[2:0])
        3'd1:    GATE_DO = 32'(dead_time_q);
        3'd2:    GATE_DO = {30'b0, fault_q, enable_q};
        3'd3:    GATE_DO = {20'b0, leg_code, GATE_OUT};
        default: GATE_DO = '0;
      endcase
    end
  end

endmodule
`default_nettype wire
